// File: rtl/k423_wb_stage.sv
// Write-back stage: completes loads against the data-memory response, writes the
// register file, redirects the PC and reports retirement. Optional: K423_WB_INSTRET_EN.
`ifndef CORE_XLEN
  `define CORE_XLEN 32
`endif
`ifndef CORE_ADDR_W
  `define CORE_ADDR_W 32
`endif
`ifndef INST_RSDIDX_W
  `define INST_RSDIDX_W 5
`endif
`ifndef LS_SIZE_W
  `define LS_SIZE_W 2
`endif

module k423_wb_stage #(
  parameter int XLEN   = `CORE_XLEN,
  parameter int ADDR_W = `CORE_ADDR_W,
  parameter int RIDX_W = `INST_RSDIDX_W,
  parameter int LSZ_W  = `LS_SIZE_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pcu_clear_wb_i,
  input  logic              ex2wb_stage_vld_i,
  output logic              wb_stage_rdy_o,
  input  logic [ADDR_W-1:0] wb_pc_i,
  input  logic              wb_rd_vld_i,
  input  logic [RIDX_W-1:0] wb_rd_idx_i,
  input  logic [XLEN-1:0]   wb_rd_i,
  input  logic              wb_rd_load_i,
  input  logic [LSZ_W-1:0]  wb_rd_load_size_i,
  input  logic              wb_rd_load_unsigned_i,
  input  logic [ADDR_W-1:0] wb_rd_load_addr_i,
  input  logic              wb_excp_br_tkn_i,
  input  logic [XLEN-1:0]   wb_excp_br_pc_i,
  input  logic              wb_bju_br_tkn_i,
  input  logic [XLEN-1:0]   wb_bju_br_pc_i,
  input  logic              dmem_rsp_vld_i,
  input  logic [XLEN-1:0]   dmem_rsp_data_i,
  output logic              rf_wr_en_o,
  output logic [RIDX_W-1:0] rf_wr_idx_o,
  output logic [XLEN-1:0]   rf_wr_data_o,
  output logic              redirect_vld_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              retire_vld_o,
  output logic [ADDR_W-1:0] retire_pc_o,
  output logic [63:0]       instret_o,
  output logic [1:0]        wb_state_o
);

  // Handshake: the EX/WB register advances on any cycle where
  // ex2wb_stage_vld_i & wb_stage_rdy_o; an instruction that is held (rdy=0)
  // must keep all of its wb_* fields stable until rdy rises.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic load_miss;
  logic commit;
  logic [XLEN-1:0] load_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        wb_unused;

  assign load_miss = ex2wb_stage_vld_i & wb_rd_load_i & ~dmem_rsp_vld_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_miss) begin
          state_d = pcu_clear_wb_i ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A flush coinciding with the response simply drops the load.
        if (dmem_rsp_vld_i) begin
          state_d = ST_IDLE;
        end else if (pcu_clear_wb_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dmem_rsp_vld_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: commit qualifier and ready
  always_comb begin
    commit         = 1'b0;
    wb_stage_rdy_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        commit         = ex2wb_stage_vld_i & ~pcu_clear_wb_i &
                         (~wb_rd_load_i | dmem_rsp_vld_i);
        wb_stage_rdy_o = ~(load_miss & ~pcu_clear_wb_i);
      end
      ST_WAIT: begin
        commit         = ex2wb_stage_vld_i & ~pcu_clear_wb_i & dmem_rsp_vld_i;
        wb_stage_rdy_o = dmem_rsp_vld_i | pcu_clear_wb_i;
      end
      ST_DRAIN: begin
        commit         = 1'b0;
        wb_stage_rdy_o = 1'b0;
      end
      default: begin
        commit         = 1'b0;
        wb_stage_rdy_o = 1'b0;
      end
    endcase
    if (!rst_n_i) begin
      commit         = 1'b0;
      wb_stage_rdy_o = 1'b0;
    end
  end

  // Load alignment; the response is a word, the low address bits pick the lane.
  assign byte_v = dmem_rsp_data_i[{wb_rd_load_addr_i[1:0], 3'b000} +: 8];
  assign half_v = wb_rd_load_addr_i[1] ? dmem_rsp_data_i[31:16] : dmem_rsp_data_i[15:0];

  always_comb begin
    load_data = dmem_rsp_data_i;
    case (wb_rd_load_size_i)
      LSZ_W'(0): load_data = {{(XLEN-8){~wb_rd_load_unsigned_i & byte_v[7]}}, byte_v};
      LSZ_W'(1): load_data = {{(XLEN-16){~wb_rd_load_unsigned_i & half_v[15]}}, half_v};
      default:   load_data = dmem_rsp_data_i;
    endcase
  end

  assign wb_unused = ^wb_rd_load_addr_i[ADDR_W-1:2];

  always_comb begin
    rf_wr_en_o     = commit & wb_rd_vld_i & (wb_rd_idx_i != '0);
    rf_wr_idx_o    = commit ? wb_rd_idx_i : '0;
    rf_wr_data_o   = '0;
    redirect_vld_o = commit & (wb_excp_br_tkn_i | wb_bju_br_tkn_i);
    redirect_pc_o  = '0;
    if (commit) begin
      rf_wr_data_o  = wb_rd_load_i ? load_data : wb_rd_i;
      redirect_pc_o = wb_excp_br_tkn_i ? wb_excp_br_pc_i : wb_bju_br_pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      retire_vld_o <= 1'b0;
      retire_pc_o  <= '0;
    end else begin
      retire_vld_o <= commit;
      retire_pc_o  <= wb_pc_i;
    end
  end

`ifdef K423_WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instret_q <= '0;
    end else if (commit) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

  assign wb_state_o = state_q;

endmodule

// File: tb/tb_k423_wb_stage.sv
// Self-checking bench for k423_wb_stage: directed scenarios plus randomized
// transactions scored against a behavioural model. Honours K423_WB_INSTRET_EN.
module tb_k423_wb_stage;

  localparam int XLEN = 32;
  localparam int ADDR_W = 32;
  localparam int RIDX_W = 5;
  localparam int LSZ_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic clk, rst_n, clear, vld, rdy;
  logic [ADDR_W-1:0] pc;
  logic rd_vld;
  logic [RIDX_W-1:0] rd_idx;
  logic [XLEN-1:0] rd;
  logic load;
  logic [LSZ_W-1:0] lsize;
  logic luns;
  logic [ADDR_W-1:0] laddr;
  logic excp_tkn, bju_tkn;
  logic [XLEN-1:0] excp_pc, bju_pc;
  logic rsp_vld;
  logic [XLEN-1:0] rsp_data;
  logic rf_wr_en;
  logic [RIDX_W-1:0] rf_wr_idx;
  logic [XLEN-1:0] rf_wr_data;
  logic redirect_vld;
  logic [XLEN-1:0] redirect_pc;
  logic retire_vld;
  logic [ADDR_W-1:0] retire_pc;
  logic [63:0] instret;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail = 0;
  logic [RIDX_W+XLEN-1:0] exp_q[$];

  k423_wb_stage dut (
    .clk_i(clk), .rst_n_i(rst_n), .pcu_clear_wb_i(clear),
    .ex2wb_stage_vld_i(vld), .wb_stage_rdy_o(rdy), .wb_pc_i(pc),
    .wb_rd_vld_i(rd_vld), .wb_rd_idx_i(rd_idx), .wb_rd_i(rd),
    .wb_rd_load_i(load), .wb_rd_load_size_i(lsize),
    .wb_rd_load_unsigned_i(luns), .wb_rd_load_addr_i(laddr),
    .wb_excp_br_tkn_i(excp_tkn), .wb_excp_br_pc_i(excp_pc),
    .wb_bju_br_tkn_i(bju_tkn), .wb_bju_br_pc_i(bju_pc),
    .dmem_rsp_vld_i(rsp_vld), .dmem_rsp_data_i(rsp_data),
    .rf_wr_en_o(rf_wr_en), .rf_wr_idx_o(rf_wr_idx), .rf_wr_data_o(rf_wr_data),
    .redirect_vld_o(redirect_vld), .redirect_pc_o(redirect_pc),
    .retire_vld_o(retire_vld), .retire_pc_o(retire_pc),
    .instret_o(instret), .wb_state_o(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_load(input int size, input logic [31:0] addr,
                                           input logic [31:0] data, input bit uns);
    longint unsigned v;
    int lane;
    lane = int'(addr % 4);
    if (size == 0) begin
      v = (data >> (8 * lane)) % 256;
      if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (size == 1) begin
      v = (lane >= 2) ? data / 65536 : data % 65536;
      if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = data;
    end
    return v[31:0];
  endfunction

  function automatic logic [63:0] exp_instret(input int commits);
`ifdef K423_WB_INSTRET_EN
    return 64'(commits);
`else
    return 64'd0 + 0 * commits;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    clear = 0; vld = 0; pc = '0; rd_vld = 0; rd_idx = '0; rd = '0;
    load = 0; lsize = '0; luns = 0; laddr = '0;
    excp_tkn = 0; excp_pc = '0; bju_tkn = 0; bju_pc = '0;
    rsp_vld = 0; rsp_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 0;
    idle_inputs();
    #2;
    rst_n = 1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    vld = 1; rd_vld = 1; rd_idx = 5; rd = 32'h1234; excp_tkn = 1; excp_pc = 32'h100;
    @(negedge clk);
    n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0h exp 0", rf_wr_en); end
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %0h exp 0", rdy); end
    n_checks++; if (redirect_vld !== 1'b0) begin n_fail++; $display("FAIL reset_redirect: got %0h exp 0", redirect_vld); end
    n_checks++; if (rf_wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %0h exp 0", rf_wr_data); end
    n_checks++; if (retire_vld !== 1'b0 || retire_pc !== '0) begin n_fail++; $display("FAIL reset_retire: got %0h/%0h exp 0/0", retire_vld, retire_pc); end
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp %0d", state, ST_IDLE); end
    n_checks++; if (instret !== 64'd0) begin n_fail++; $display("FAIL reset_instret: got %0d exp 0", instret); end
    tick();
    rst_n = 1;
    idle_inputs();
    tick();
  endtask

  task automatic test_alu();
    idle_inputs();
    vld = 1; rd_vld = 1; rd_idx = 5; rd = 32'h1234; pc = 32'h400;
    @(negedge clk);
    n_checks++; if (rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL alu_wr_en: got %0h exp 1", rf_wr_en); end
    n_checks++; if (rf_wr_idx !== 5'd5) begin n_fail++; $display("FAIL alu_wr_idx: got %0d exp 5", rf_wr_idx); end
    n_checks++; if (rf_wr_data !== 32'h1234) begin n_fail++; $display("FAIL alu_wr_data: got %0h exp 1234", rf_wr_data); end
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL alu_rdy: got %0h exp 1", rdy); end
    n_checks++; if (redirect_vld !== 1'b0) begin n_fail++; $display("FAIL alu_redirect: got %0h exp 0", redirect_vld); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (retire_vld !== 1'b1 || retire_pc !== 32'h400) begin n_fail++; $display("FAIL alu_retire: got %0h/%0h exp 1/400", retire_vld, retire_pc); end
    n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL alu_idle_wr_en: got %0h exp 0", rf_wr_en); end
    tick();
  endtask

  task automatic test_load_same_cycle();
    for (int u = 0; u < 2; u++) begin
      idle_inputs();
      vld = 1; load = 1; lsize = 0; laddr = 32'h1003; luns = u[0]; rd_vld = 1;
      rd_idx = 7; rd = 32'hDEAD; pc = 32'h440 + 4 * u; rsp_vld = 1; rsp_data = 32'h80FF_FFFF;
      @(negedge clk);
      n_checks++; if (rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL lb_wr_en[%0d]: got %0h exp 1", u, rf_wr_en); end
      n_checks++; if (rf_wr_data !== exp_load(0, 32'h1003, 32'h80FF_FFFF, u[0])) begin n_fail++; $display("FAIL lb_data[%0d]: got %0h exp %0h", u, rf_wr_data, exp_load(0, 32'h1003, 32'h80FF_FFFF, u[0])); end
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL lb_rdy[%0d]: got %0h exp 1", u, rdy); end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (retire_vld !== 1'b1 || retire_pc !== 32'h444) begin n_fail++; $display("FAIL lb_retire: got %0h/%0h exp 1/444", retire_vld, retire_pc); end
    tick();
  endtask

  task automatic test_delayed_load();
    idle_inputs();
    vld = 1; load = 1; lsize = 1; laddr = 32'h2002; luns = 0; rd_vld = 1; rd_idx = 9; pc = 32'h500;
    for (int c = 0; c < 3; c++) begin
      rsp_vld = 0; rsp_data = $urandom;
      @(negedge clk);
      n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL dl_rdy[%0d]: got %0h exp 0", c, rdy); end
      n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL dl_wr_en[%0d]: got %0h exp 0", c, rf_wr_en); end
      if (c > 0) begin
        n_checks++; if (state !== ST_WAIT) begin n_fail++; $display("FAIL dl_state[%0d]: got %0d exp %0d", c, state, ST_WAIT); end
      end
      tick();
    end
    rsp_vld = 1; rsp_data = 32'hBEEF_0000;
    @(negedge clk);
    n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_idx !== 5'd9) begin n_fail++; $display("FAIL dl_wr: got %0h/%0d exp 1/9", rf_wr_en, rf_wr_idx); end
    n_checks++; if (rf_wr_data !== exp_load(1, 32'h2002, 32'hBEEF_0000, 1'b0)) begin n_fail++; $display("FAIL dl_data: got %0h exp %0h", rf_wr_data, exp_load(1, 32'h2002, 32'hBEEF_0000, 1'b0)); end
    n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL dl_rdy_rsp: got %0h exp 1", rdy); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL dl_state_end: got %0d exp %0d", state, ST_IDLE); end
    n_checks++; if (retire_vld !== 1'b1 || retire_pc !== 32'h500) begin n_fail++; $display("FAIL dl_retire: got %0h/%0h exp 1/500", retire_vld, retire_pc); end
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    vld = 1; load = 1; lsize = 2; laddr = 32'h3000; rd_vld = 1; rd_idx = 3; pc = 32'h600;
    @(negedge clk);
    n_checks++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL fl_rdy0: got %0h exp 0", rdy); end
    tick();
    clear = 1;
    @(negedge clk);
    n_checks++; if (state !== ST_WAIT) begin n_fail++; $display("FAIL fl_state_wait: got %0d exp %0d", state, ST_WAIT); end
    n_checks++; if (rdy !== 1'b1 || rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL fl_clear: got rdy=%0h en=%0h exp 1/0", rdy, rf_wr_en); end
    tick();
    // Next instruction is an ALU op that must wait behind the draining load.
    clear = 0; load = 0; lsize = 0; laddr = '0; rd_idx = 4; rd = 32'h55; pc = 32'h604;
    for (int c = 0; c < 2; c++) begin
      rsp_vld = (c == 1); rsp_data = 32'hCAFE_F00D;
      @(negedge clk);
      n_checks++; if (state !== ST_DRAIN) begin n_fail++; $display("FAIL fl_state_drain[%0d]: got %0d exp %0d", c, state, ST_DRAIN); end
      n_checks++; if (rdy !== 1'b0 || rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL fl_drain[%0d]: got rdy=%0h en=%0h exp 0/0", c, rdy, rf_wr_en); end
      n_checks++; if (retire_vld !== 1'b0) begin n_fail++; $display("FAIL fl_retire[%0d]: got %0h exp 0", c, retire_vld); end
      tick();
    end
    rsp_vld = 0;
    @(negedge clk);
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL fl_state_idle: got %0d exp %0d", state, ST_IDLE); end
    n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_data !== 32'h55) begin n_fail++; $display("FAIL fl_next: got %0h/%0h exp 1/55", rf_wr_en, rf_wr_data); end
    n_checks++; if (retire_vld !== 1'b0) begin n_fail++; $display("FAIL fl_no_retire: got %0h exp 0", retire_vld); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (retire_vld !== 1'b1 || retire_pc !== 32'h604) begin n_fail++; $display("FAIL fl_retire_next: got %0h/%0h exp 1/604", retire_vld, retire_pc); end
    tick();
  endtask

  task automatic test_redirect();
    idle_inputs();
    vld = 1; rd_vld = 1; rd_idx = 0; rd = 32'h77;
    excp_tkn = 1; excp_pc = 32'h100; bju_tkn = 1; bju_pc = 32'h200;
    @(negedge clk);
    n_checks++; if (redirect_vld !== 1'b1 || redirect_pc !== 32'h100) begin n_fail++; $display("FAIL rd_prio: got %0h/%0h exp 1/100", redirect_vld, redirect_pc); end
    n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL rd_x0: got %0h exp 0", rf_wr_en); end
    tick();
    excp_tkn = 0;
    @(negedge clk);
    n_checks++; if (redirect_vld !== 1'b1 || redirect_pc !== 32'h200) begin n_fail++; $display("FAIL rd_bju: got %0h/%0h exp 1/200", redirect_vld, redirect_pc); end
    tick();
    clear = 1;
    @(negedge clk);
    n_checks++; if (redirect_vld !== 1'b0 || rdy !== 1'b1) begin n_fail++; $display("FAIL rd_killed: got redir=%0h rdy=%0h exp 0/1", redirect_vld, rdy); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (retire_vld !== 1'b0) begin n_fail++; $display("FAIL rd_kill_retire: got %0h exp 0", retire_vld); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs();
    vld = 1; load = 1; lsize = 2; rd_vld = 1; rd_idx = 6; pc = 32'h700;
    tick();
    @(negedge clk);
    n_checks++; if (state !== ST_WAIT) begin n_fail++; $display("FAIL rw_wait: got %0d exp %0d", state, ST_WAIT); end
    #1 rst_n = 0;
    #1;
    n_checks++; if (state !== ST_IDLE || rdy !== 1'b0 || rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL rw_in_reset: got st=%0d rdy=%0h en=%0h exp 0/0/0", state, rdy, rf_wr_en); end
    tick();
    rst_n = 1;
    idle_inputs();
    rsp_vld = 1; rsp_data = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if (rf_wr_en !== 1'b0 || rdy !== 1'b1) begin n_fail++; $display("FAIL rw_stray: got en=%0h rdy=%0h exp 0/1", rf_wr_en, rdy); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (state !== ST_IDLE || retire_vld !== 1'b0) begin n_fail++; $display("FAIL rw_after: got st=%0d ret=%0h exp 0/0", state, retire_vld); end
    tick();
  endtask

  task automatic test_instret();
    reset_pulse();
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      vld = 1; rd_vld = 1; rd_idx = 5'($urandom_range(0, 31)); rd = $urandom; pc = 32'h800 + 4 * i;
      tick();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (instret !== exp_instret(10)) begin n_fail++; $display("FAIL instret10: got %0d exp %0d", instret, exp_instret(10)); end
    tick();
  endtask

  task automatic test_random();
    bit is_load, kill, write_exp, last, prev_commit;
    int size, delay, commits;
    logic [31:0] addr, data, t_pc, t_rd, t_epc, t_bpc;
    logic [4:0] t_idx;
    bit t_uns, t_rdv, t_exc, t_bju;
    logic [RIDX_W+XLEN-1:0] got, expd;
    reset_pulse();
    prev_commit = 0; commits = 0; t_pc = '0;
    for (int n = 0; n < 120; n++) begin
      is_load = $urandom_range(0, 1); size = $urandom_range(0, 3); addr = $urandom;
      t_uns = $urandom_range(0, 1); t_idx = 5'($urandom_range(0, 31)); t_rdv = $urandom_range(0, 3) != 0;
      t_rd = $urandom; data = $urandom; t_exc = $urandom_range(0, 4) == 0; t_bju = $urandom_range(0, 3) == 0;
      t_epc = $urandom; t_bpc = $urandom; kill = $urandom_range(0, 5) == 0;
      delay = is_load ? $urandom_range(0, 3) : 0;
      write_exp = !kill && t_rdv && t_idx != 0;
      if (write_exp) exp_q.push_back({t_idx, is_load ? exp_load(size, addr, data, t_uns) : t_rd});
      for (int c = 0; c <= delay; c++) begin
        last = (c == delay);
        idle_inputs();
        vld = 1; load = is_load; lsize = 2'(size); laddr = addr; luns = t_uns;
        rd_vld = t_rdv; rd_idx = t_idx; rd = t_rd; pc = 32'h1000 + 4 * n;
        excp_tkn = t_exc; excp_pc = t_epc; bju_tkn = t_bju; bju_pc = t_bpc;
        rsp_vld = is_load ? last : 1'($urandom_range(0, 1));
        rsp_data = last ? data : $urandom;
        clear = kill && last;
        @(negedge clk);
        n_checks++; if (rdy !== last) begin n_fail++; $display("FAIL rnd_rdy[%0d.%0d]: got %0h exp %0h", n, c, rdy, last); end
        n_checks++; if (rf_wr_en !== (last && write_exp)) begin n_fail++; $display("FAIL rnd_wr_en[%0d.%0d]: got %0h exp %0h", n, c, rf_wr_en, last && write_exp); end
        if (rf_wr_en === 1'b1) begin
          got = {rf_wr_idx, rf_wr_data};
          n_checks++;
          if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_wr_extra[%0d]: got %0h exp none", n, got); end
          else begin
            expd = exp_q.pop_front();
            if (got !== expd) begin n_fail++; $display("FAIL rnd_wr_data[%0d]: got %0h exp %0h", n, got, expd); end
          end
        end
        n_checks++; if (redirect_vld !== (last && !kill && (t_exc || t_bju))) begin n_fail++; $display("FAIL rnd_redir_vld[%0d.%0d]: got %0h exp %0h", n, c, redirect_vld, last && !kill && (t_exc || t_bju)); end
        if (last && !kill && (t_exc || t_bju)) begin
          n_checks++; if (redirect_pc !== (t_exc ? t_epc : t_bpc)) begin n_fail++; $display("FAIL rnd_redir_pc[%0d]: got %0h exp %0h", n, redirect_pc, t_exc ? t_epc : t_bpc); end
        end
        n_checks++; if (retire_vld !== prev_commit) begin n_fail++; $display("FAIL rnd_retire_vld[%0d.%0d]: got %0h exp %0h", n, c, retire_vld, prev_commit); end
        if (prev_commit) begin
          n_checks++; if (retire_pc !== t_pc) begin n_fail++; $display("FAIL rnd_retire_pc[%0d]: got %0h exp %0h", n, retire_pc, t_pc); end
        end
        prev_commit = last && !kill;
        t_pc = 32'h1000 + 4 * n;
        if (prev_commit) commits++;
        tick();
      end
    end
    idle_inputs();
    @(negedge clk);
    n_checks++; if (retire_vld !== prev_commit) begin n_fail++; $display("FAIL rnd_retire_last: got %0h exp %0h", retire_vld, prev_commit); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_pending: got %0d exp 0 writes outstanding", exp_q.size()); end
    n_checks++; if (instret !== exp_instret(commits)) begin n_fail++; $display("FAIL rnd_instret: got %0d exp %0d", instret, exp_instret(commits)); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_alu();
    test_load_same_cycle();
    test_delayed_load();
    test_flush();
    test_redirect();
    test_reset_mid_wait();
    test_instret();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/k423_wb_stage.md
Name: k423_wb_stage

Overview:
- Write-back stage; consumes the EX/WB pipeline register outputs.
- Finishes loads by waiting for the data-memory response, then aligns and extends the load data.
- Writes the register file, issues the PC redirect for taken exception/branch, and reports retired instructions.
- Drives the ready signal back to the EX/WB pipeline, so a slow load response stalls the upstream stage.

Parameters:
- XLEN, `CORE_XLEN (32): register/data width.
- ADDR_W, `CORE_ADDR_W (32): address/PC width.
- RIDX_W, `INST_RSDIDX_W (5): register index width.
- LSZ_W, `LS_SIZE_W (2): load size encoding width; 0=byte, 1=half, 2=word.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- pcu_clear_wb_i  in  1  flush: kill the instruction currently in WB
- ex2wb_stage_vld_i  in  1  valid instruction present in EX/WB register
- wb_stage_rdy_o  out  1  WB accepts/completes this cycle; upstream advances only when 1
- wb_pc_i  in  ADDR_W  instruction PC
- wb_rd_vld_i  in  1  instruction writes rd
- wb_rd_idx_i  in  RIDX_W  destination index
- wb_rd_i  in  XLEN  ALU/CSR result (non-load)
- wb_rd_load_i  in  1  instruction is a load
- wb_rd_load_size_i  in  LSZ_W  load size
- wb_rd_load_unsigned_i  in  1  zero-extend when 1
- wb_rd_load_addr_i  in  ADDR_W  load byte address
- wb_excp_br_tkn_i / wb_excp_br_pc_i  in  1 / XLEN  exception redirect
- wb_bju_br_tkn_i / wb_bju_br_pc_i  in  1 / XLEN  branch redirect
- dmem_rsp_vld_i  in  1  load data valid, one-cycle pulse
- dmem_rsp_data_i  in  XLEN  word-aligned load data
- rf_wr_en_o / rf_wr_idx_o / rf_wr_data_o  out  1 / RIDX_W / XLEN  register file write port
- redirect_vld_o / redirect_pc_o  out  1 / XLEN  PC redirect to the PCU
- retire_vld_o / retire_pc_o  out  1 / ADDR_W  registered retire report
- instret_o  out  64  retired-instruction count (optional feature only)

Behaviour:
- FSM states: IDLE, WAIT (load issued, response pending), DRAIN (flushed load, response pending). Reset state is IDLE.
- commit = ex2wb_stage_vld_i & ~pcu_clear_wb_i & ((IDLE & (~load | dmem_rsp_vld_i)) | (WAIT & dmem_rsp_vld_i)).
- wb_stage_rdy_o, combinational:
  - IDLE: 1 unless (vld & load & ~dmem_rsp_vld_i & ~clear).
  - WAIT: dmem_rsp_vld_i | pcu_clear_wb_i.
  - DRAIN: 0.
- FSM transitions:
  - IDLE -> WAIT on vld & load & ~rsp & ~clear.
  - IDLE -> DRAIN on vld & load & ~rsp & clear.
  - WAIT -> IDLE on rsp.
  - WAIT -> DRAIN on clear & ~rsp; clear & rsp in the same cycle -> IDLE, no write.
  - DRAIN -> IDLE on rsp; the response is discarded.
- Load data: sh = 8*addr[1:0].
  - Byte: bits [sh+7:sh].
  - Half: addr[1] selects the upper or lower half; addr[0] is ignored (misalignment is trapped upstream).
  - Word: full data, addr ignored.
  - Sign-extend unless unsigned. Size value 3 is treated as word.
- Register file write, combinational in the commit cycle:
  - rf_wr_en_o = commit & rd_vld & (rd_idx != 0).
  - rf_wr_data_o = aligned load data if load, else wb_rd_i.
  - rf_wr_idx_o = wb_rd_idx_i.
- Redirect, combinational:
  - redirect_vld_o = commit & (excp_tkn | bju_tkn).
  - redirect_pc_o = excp_pc if excp_tkn, else bju_pc; exception has priority.
- A response arriving in IDLE with no pending load is ignored.
- Retire report: retire_vld_o <= commit and retire_pc_o <= wb_pc_i on the next edge (latency 1). Reset values are 0/0.
- Combinational outputs are 0 while rst_n_i is low and whenever the stage does not commit.
- Reset mid-WAIT returns to IDLE; any later stray response is ignored in IDLE.

Optional Feature:
- Macro: K423_WB_INSTRET_EN.
- Defined: 64-bit counter, reset 0, increments by 1 on each commit, wraps at 2^64; driven on instret_o.
- Undefined: no counter logic; instret_o tied to 0.

Test Plan:
- ALU op: vld=1, load=0, rd_idx=5, rd=0x1234 -> same cycle rf_wr_en=1, idx=5, data=0x1234, rdy=1; next cycle retire_vld=1 with the PC.
- Signed byte load: addr=0x1003, rsp same cycle with data=0x80FF_FFFF -> data=0xFFFF_FF80; repeat with unsigned=1 -> 0x0000_0080.
- Delayed load: half, addr=0x2002, rsp after 3 cycles with data=0xBEEF_0000, unsigned=0 -> WAIT for 3 cycles with rdy=0, then data=0xFFFF_BEEF, rdy=1, state IDLE.
- Flush mid-wait: clear during WAIT, rsp 2 cycles later -> no rf write, no retire, rdy=0 in DRAIN, IDLE after the rsp.
- Redirect priority: excp_tkn=1 with pc=0x100 and bju_tkn=1 with pc=0x200 -> redirect_vld=1, pc=0x100. rd_idx=0 with rd_vld=1 -> rf_wr_en=0.
- Reset asserted during WAIT, then a stray rsp -> IDLE, no writes. With K423_WB_INSTRET_EN, instret_o counts commits exactly (10 commits -> 10).
